// File: rtl/blk_010fd2.sv
// Receive side of one router-wrap slice data lane: flit FIFO with valid/ready
// output, per-pop credit return and a head/tail framing checker with sticky flags.
module blk_010fd2 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         set,
    input  logic                         idata_in_valid,
    input  logic [DATA_WIDTH-1:0]        idata_in_data,
    input  logic                         idata_in_head,
    input  logic                         idata_in_tail,
    output logic                         idata_out_valid,
    output logic [DATA_WIDTH-1:0]        idata_out_data,
    output logic                         idata_out_head,
    output logic                         idata_out_tail,
    input  logic                         idata_out_ready,
    output logic                         idata_credit_out,
    output logic [$clog2(DEPTH+1)-1:0]   idata_count,
    output logic                         idata_overflow,
    output logic                         idata_frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic {
        ST_IDLE,
        ST_BODY
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            credit_q, credit_d;
    logic            overflow_q, overflow_d;
    logic            frame_err_q, frame_err_d;
    logic            full;
    logic            pop;
    logic            push;
    logic            unused_set;

    assign unused_set = set;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && idata_out_ready;
    assign push = idata_in_valid && (!full || pop);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        credit_d    = pop;
        overflow_d  = overflow_q | (idata_in_valid & ~push);
        frame_err_d = frame_err_q;
        state_d     = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = {idata_in_head, idata_in_tail, idata_in_data};
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!idata_in_head) frame_err_d = 1'b1;
                    if (idata_in_head && !idata_in_tail) state_d = ST_BODY;
                end
                ST_BODY: begin
                    if (idata_in_head) frame_err_d = 1'b1;
                    if (idata_in_tail) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            credit_q    <= credit_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign idata_out_valid  = (count_q != '0);
    assign {idata_out_head, idata_out_tail, idata_out_data} = mem_q[rd_ptr_q];
    assign idata_credit_out = credit_q;
    assign idata_count      = count_q;
    assign idata_overflow   = overflow_q;
    assign idata_frame_err  = frame_err_q;

endmodule

// File: tb/tb_blk_010fd2.sv
// Bench for blk_010fd2: directed scenarios plus randomized traffic checked
// against a queue-based model of the lane receiver.
module tb_blk_010fd2;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct {
        bit            h;
        bit            t;
        logic [DW-1:0] d;
    } flit_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          set = 1'b0;
    logic          idata_in_valid = 1'b0;
    logic [DW-1:0] idata_in_data = '0;
    logic          idata_in_head = 1'b0;
    logic          idata_in_tail = 1'b0;
    logic          idata_out_valid;
    logic [DW-1:0] idata_out_data;
    logic          idata_out_head;
    logic          idata_out_tail;
    logic          idata_out_ready = 1'b0;
    logic          idata_credit_out;
    logic [CW-1:0] idata_count;
    logic          idata_overflow;
    logic          idata_frame_err;

    int tests = 0;
    int fails = 0;

    flit_t mq[$];
    bit    m_ovf, m_err, m_in_packet, m_credit;

    always #5 clk = ~clk;

    blk_010fd2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .set(set),
        .idata_in_valid(idata_in_valid), .idata_in_data(idata_in_data),
        .idata_in_head(idata_in_head), .idata_in_tail(idata_in_tail),
        .idata_out_valid(idata_out_valid), .idata_out_data(idata_out_data),
        .idata_out_head(idata_out_head), .idata_out_tail(idata_out_tail),
        .idata_out_ready(idata_out_ready), .idata_credit_out(idata_credit_out),
        .idata_count(idata_count), .idata_overflow(idata_overflow),
        .idata_frame_err(idata_frame_err)
    );

    task automatic model_clear();
        mq.delete();
        m_ovf = 0; m_err = 0; m_in_packet = 0; m_credit = 0;
    endtask

    task automatic do_reset();
        idata_in_valid = 0; idata_out_ready = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_clear();
    endtask

    // Drive one cycle, advance the model by the lane rules, sample 1 time unit after the edge.
    task automatic cycle(input bit vin, input logic [DW-1:0] d, input bit h, input bit t, input bit rdy);
        bit    do_pop, do_push;
        flit_t f;
        idata_in_valid = vin; idata_in_data = d; idata_in_head = h; idata_in_tail = t;
        idata_out_ready = rdy;
        do_pop  = (mq.size() != 0) && rdy;
        do_push = vin && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) f = mq.pop_front();
        if (do_push) begin
            f.h = h; f.t = t; f.d = d;
            mq.push_back(f);
            if (m_in_packet) begin
                if (h) m_err = 1;
                m_in_packet = !t;
            end else begin
                if (!h) m_err = 1;
                m_in_packet = h && !t;
            end
        end
        if (vin && !do_push) m_ovf = 1;
        m_credit = do_pop;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        @(posedge clk); #1;
        tests++; if (idata_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", idata_out_valid); end
        tests++; if (idata_count !== '0) begin fails++; $display("FAIL rst_count got=%0d exp=0", idata_count); end
        tests++; if (idata_credit_out !== 1'b0) begin fails++; $display("FAIL rst_credit got=%b exp=0", idata_credit_out); end
        tests++; if ({idata_overflow, idata_frame_err} !== 2'b00) begin fails++; $display("FAIL rst_flags got=%b exp=00", {idata_overflow, idata_frame_err}); end
        #1 reset = 0;
        model_clear();
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + i, 1, 1, 0);
        tests++; if (idata_count !== 3'd4) begin fails++; $display("FAIL fill_count got=%0d exp=4", idata_count); end
        tests++; if (idata_out_data !== 32'hA0) begin fails++; $display("FAIL fill_head got=%0h exp=a0", idata_out_data); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (idata_out_data !== 32'hA0 + i) begin fails++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, idata_out_data, 32'hA0 + i); end
            cycle(0, 0, 0, 0, 1);
            tests++; if (idata_credit_out !== 1'b1) begin fails++; $display("FAIL drain_credit[%0d] got=%b exp=1", i, idata_credit_out); end
        end
        tests++; if (idata_count !== 3'd0) begin fails++; $display("FAIL drain_count got=%0d exp=0", idata_count); end
        cycle(0, 0, 0, 0, 1);
        tests++; if ({idata_out_valid, idata_credit_out, idata_overflow, idata_frame_err} !== 4'b0000) begin
            fails++; $display("FAIL drain_idle got=%b exp=0000", {idata_out_valid, idata_credit_out, idata_overflow, idata_frame_err}); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h10 + i, 1, 1, 0);
        cycle(1, 32'hBB, 1, 1, 0);
        tests++; if (idata_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", idata_overflow); end
        tests++; if (idata_count !== 3'd4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", idata_count); end
        tests++; if (idata_credit_out !== 1'b0) begin fails++; $display("FAIL ovf_credit got=%b exp=0", idata_credit_out); end
        cycle(1, 32'hCC, 1, 1, 1);
        tests++; if (idata_count !== 3'd4) begin fails++; $display("FAIL ovf_pp_count got=%0d exp=4", idata_count); end
        tests++; if ({idata_overflow, idata_credit_out} !== 2'b11) begin fails++; $display("FAIL ovf_pp_flags got=%b exp=11", {idata_overflow, idata_credit_out}); end
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] exp_d;
            exp_d = (i == 3) ? 32'hCC : 32'h11 + i;
            tests++; if (idata_out_data !== exp_d) begin fails++; $display("FAIL ovf_order[%0d] got=%0h exp=%0h", i, idata_out_data, exp_d); end
            cycle(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_framing();
        do_reset();
        cycle(1, 32'h1, 1, 0, 1);
        cycle(1, 32'h2, 0, 0, 1);
        cycle(1, 32'h3, 0, 1, 1);
        tests++; if (idata_frame_err !== 1'b0) begin fails++; $display("FAIL frm_ok got=%b exp=0", idata_frame_err); end
        cycle(1, 32'h4, 0, 0, 0);
        tests++; if (idata_frame_err !== 1'b1) begin fails++; $display("FAIL frm_body_idle got=%b exp=1", idata_frame_err); end
        cycle(0, 0, 0, 0, 1);
        tests++; if ({idata_out_valid, idata_out_head, idata_out_tail, idata_out_data} !== {3'b100, 32'h4}) begin
            fails++; $display("FAIL frm_fwd got=%b/%0h exp=100/4", {idata_out_valid, idata_out_head, idata_out_tail}, idata_out_data); end
    endtask

    task automatic test_head_head();
        do_reset();
        cycle(1, 32'h10, 1, 0, 1);
        tests++; if (idata_frame_err !== 1'b0) begin fails++; $display("FAIL hh_first got=%b exp=0", idata_frame_err); end
        cycle(1, 32'h11, 1, 0, 1);
        tests++; if (idata_frame_err !== 1'b1) begin fails++; $display("FAIL hh_err got=%b exp=1", idata_frame_err); end
        tests++; if ({idata_out_head, idata_out_tail, idata_out_data} !== {2'b10, 32'h11}) begin
            fails++; $display("FAIL hh_fwd got=%b/%0h exp=10/11", {idata_out_head, idata_out_tail}, idata_out_data); end
        cycle(1, 32'h12, 0, 1, 1);
        tests++; if ({idata_out_head, idata_out_tail, idata_out_data} !== {2'b01, 32'h12}) begin
            fails++; $display("FAIL hh_tail got=%b/%0h exp=01/12", {idata_out_head, idata_out_tail}, idata_out_data); end
    endtask

    task automatic test_back_to_back();
        int credits;
        do_reset();
        credits = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 32'h100 + i, 1, 1, 1);
            credits += idata_credit_out;
            tests++; if (idata_count !== 3'd1) begin fails++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, idata_count); end
            tests++; if (idata_out_data !== 32'h100 + i) begin fails++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, idata_out_data, 32'h100 + i); end
            tests++; if (idata_credit_out !== (i > 0)) begin fails++; $display("FAIL b2b_credit[%0d] got=%b exp=%b", i, idata_credit_out, (i > 0)); end
        end
        cycle(0, 0, 0, 0, 1);
        credits += idata_credit_out;
        tests++; if (credits != 20) begin fails++; $display("FAIL b2b_credits got=%0d exp=20", credits); end
        tests++; if (idata_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got=%b exp=0", idata_out_valid); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 20; s++) begin
            do_reset();
            for (int c = 0; c < 15; c++) begin
                cycle(($urandom % 4) != 0, $urandom, $urandom % 2, $urandom % 2, ($urandom % 3) == 0);
                tests++; if (idata_out_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_valid s%0d c%0d got=%b exp=%b", s, c, idata_out_valid, mq.size() != 0); end
                tests++; if (idata_count !== CW'(mq.size())) begin fails++; $display("FAIL rnd_count s%0d c%0d got=%0d exp=%0d", s, c, idata_count, mq.size()); end
                if (mq.size() != 0) begin
                    tests++; if ({idata_out_head, idata_out_tail, idata_out_data} !== {mq[0].h, mq[0].t, mq[0].d}) begin
                        fails++; $display("FAIL rnd_data s%0d c%0d got=%b/%0h exp=%b/%0h", s, c, {idata_out_head, idata_out_tail}, idata_out_data, {mq[0].h, mq[0].t}, mq[0].d); end
                end
                tests++; if (idata_credit_out !== m_credit) begin fails++; $display("FAIL rnd_credit s%0d c%0d got=%b exp=%b", s, c, idata_credit_out, m_credit); end
                tests++; if ({idata_overflow, idata_frame_err} !== {m_ovf, m_err}) begin
                    fails++; $display("FAIL rnd_flags s%0d c%0d got=%b exp=%b", s, c, {idata_overflow, idata_frame_err}, {m_ovf, m_err}); end
            end
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        cycle(1, 32'h21, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h22 + i, 1, 1, 0);
        cycle(0, 0, 0, 0, 1);
        tests++; if ({idata_count, idata_credit_out, idata_overflow, idata_frame_err} !== {3'd3, 3'b111}) begin
            fails++; $display("FAIL mid_pre got=%0d/%b exp=3/111", idata_count, {idata_credit_out, idata_overflow, idata_frame_err}); end
        #2 reset = 1;
        #1;
        tests++; if ({idata_out_valid, idata_count, idata_credit_out, idata_overflow, idata_frame_err} !== '0) begin
            fails++; $display("FAIL mid_async got=%b/%0d/%b exp=0/0/000", idata_out_valid, idata_count, {idata_credit_out, idata_overflow, idata_frame_err}); end
        #2 reset = 0;
        model_clear();
        cycle(0, 0, 0, 0, 0);
        tests++; if ({idata_out_valid, idata_count, idata_credit_out} !== '0) begin
            fails++; $display("FAIL mid_after got=%b/%0d/%b exp=0/0/0", idata_out_valid, idata_count, idata_credit_out); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_framing();
        test_head_head();
        test_back_to_back();
        test_random();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
